// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the shared PS/PL memory port arbiter.
// The arbiter uses the slave view; the requesters and memory model use the master view.
interface mem_port_arbiter_if;
  logic        ps_req;
  logic [2:0]  ps_cmd;
  logic [7:0]  ps_addr;
  logic [31:0] ps_wdata;
  logic        ps_gnt;
  logic        ps_rvalid;
  logic [31:0] ps_rdata;

  logic        pl_req;
  logic [2:0]  pl_cmd;
  logic [7:0]  pl_addr;
  logic [31:0] pl_wdata;
  logic        pl_gnt;
  logic        pl_rvalid;
  logic [31:0] pl_rdata;

  logic [2:0]  mem_cmd;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  ps_req, ps_cmd, ps_addr, ps_wdata,
    input  pl_req, pl_cmd, pl_addr, pl_wdata,
    input  mem_rdata,
    output ps_gnt, ps_rvalid, ps_rdata,
    output pl_gnt, pl_rvalid, pl_rdata,
    output mem_cmd, mem_addr, mem_wdata
  );

  modport master (
    output ps_req, ps_cmd, ps_addr, ps_wdata,
    output pl_req, pl_cmd, pl_addr, pl_wdata,
    output mem_rdata,
    input  ps_gnt, ps_rvalid, ps_rdata,
    input  pl_gnt, pl_rvalid, pl_rdata,
    input  mem_cmd, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the single command/address/data port of the
// 256 x 32 shared memory between the PS loader and the PL matrix calculator.
// One transaction is in flight at a time; read data goes back only to the
// requester that issued the read. Memory commands: 2 = write, 3 = read, 4 = idle.
module mem_port_arbiter #(
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus,
  output logic              busy
);

  localparam logic [2:0] CMD_WR    = 3'd2;
  localparam logic [2:0] CMD_RD    = 3'd3;
  localparam logic [2:0] CMD_IDLE  = 3'd4;
  localparam logic [3:0] WAIT_LOAD = 4'(RD_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_t;

  state_t      state_q,    state_d;
  logic [3:0]  waitCnt_q,  waitCnt_d;
  logic        lastPl_q,   lastPl_d;
  logic        ownerPl_q,  ownerPl_d;
  logic        psGnt_q,    psGnt_d;
  logic        plGnt_q,    plGnt_d;
  logic        psRvalid_q, psRvalid_d;
  logic        plRvalid_q, plRvalid_d;
  logic [31:0] psRdata_q,  psRdata_d;
  logic [31:0] plRdata_q,  plRdata_d;
  logic [2:0]  memCmd_q,   memCmd_d;
  logic [7:0]  memAddr_q,  memAddr_d;
  logic [31:0] memWdata_q, memWdata_d;

  logic psValid;
  logic plValid;
  logic pickPl;

  // Only write and read commands count as requests; anything else is ignored.
  assign psValid = bus.ps_req && (bus.ps_cmd == CMD_WR || bus.ps_cmd == CMD_RD);
  assign plValid = bus.pl_req && (bus.pl_cmd == CMD_WR || bus.pl_cmd == CMD_RD);
  // On a tie the requester not granted most recently wins.
  assign pickPl  = plValid && (!psValid || !lastPl_q);

  assign bus.ps_gnt    = psGnt_q;
  assign bus.pl_gnt    = plGnt_q;
  assign bus.ps_rvalid = psRvalid_q;
  assign bus.pl_rvalid = plRvalid_q;
  assign bus.ps_rdata  = psRdata_q;
  assign bus.pl_rdata  = plRdata_q;
  assign bus.mem_cmd   = memCmd_q;
  assign bus.mem_addr  = memAddr_q;
  assign bus.mem_wdata = memWdata_q;
  assign busy          = (state_q != IDLE);

  // Next-state and registered-output logic for the IDLE/ISSUE/RD_WAIT sequence.
  always_comb begin
    state_d    = state_q;
    waitCnt_d  = waitCnt_q;
    lastPl_d   = lastPl_q;
    ownerPl_d  = ownerPl_q;
    psGnt_d    = 1'b0;
    plGnt_d    = 1'b0;
    psRvalid_d = 1'b0;
    plRvalid_d = 1'b0;
    psRdata_d  = psRdata_q;
    plRdata_d  = plRdata_q;
    memCmd_d   = memCmd_q;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;

    case (state_q)
      IDLE: begin
        if (psValid || plValid) begin
          ownerPl_d = pickPl;
          lastPl_d  = pickPl;
          state_d   = ISSUE;
          if (pickPl) begin
            plGnt_d    = 1'b1;
            memCmd_d   = bus.pl_cmd;
            memAddr_d  = bus.pl_addr;
            memWdata_d = bus.pl_wdata;
          end else begin
            psGnt_d    = 1'b1;
            memCmd_d   = bus.ps_cmd;
            memAddr_d  = bus.ps_addr;
            memWdata_d = bus.ps_wdata;
          end
        end
      end
      ISSUE: begin
        memCmd_d = CMD_IDLE;
        if (memCmd_q == CMD_RD) begin
          waitCnt_d = WAIT_LOAD;
          state_d   = RD_WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        if (waitCnt_q == 4'd0) begin
          state_d = IDLE;
          if (ownerPl_q) begin
            plRdata_d  = bus.mem_rdata;
            plRvalid_d = 1'b1;
          end else begin
            psRdata_d  = bus.mem_rdata;
            psRvalid_d = 1'b1;
          end
        end else begin
          waitCnt_d = waitCnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      waitCnt_q  <= 4'd0;
      lastPl_q   <= 1'b1;
      ownerPl_q  <= 1'b0;
      psGnt_q    <= 1'b0;
      plGnt_q    <= 1'b0;
      psRvalid_q <= 1'b0;
      plRvalid_q <= 1'b0;
      psRdata_q  <= 32'd0;
      plRdata_q  <= 32'd0;
      memCmd_q   <= CMD_IDLE;
      memAddr_q  <= 8'd0;
      memWdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      lastPl_q   <= lastPl_d;
      ownerPl_q  <= ownerPl_d;
      psGnt_q    <= psGnt_d;
      plGnt_q    <= plGnt_d;
      psRvalid_q <= psRvalid_d;
      plRvalid_q <= plRvalid_d;
      psRdata_q  <= psRdata_d;
      plRdata_q  <= plRdata_d;
      memCmd_q   <= memCmd_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a main instance (RD_LAT=2) exercised with
// directed and random transactions against a transaction-level model, plus
// RD_LAT=1 and RD_LAT=5 instances checked for read latency and data.
module tb_mem_port_arbiter;

  localparam int LAT0 = 2;
  localparam int LAT1 = 1;
  localparam int LAT5 = 5;
  localparam logic [2:0] CMD_WR   = 3'd2;
  localparam logic [2:0] CMD_RD   = 3'd3;
  localparam logic [2:0] CMD_IDLE = 3'd4;

  logic clk = 1'b0;
  logic rst;
  logic busy0, busy1, busy5;
  int   checks = 0;
  int   errors = 0;

  logic        altReq;
  logic [2:0]  altCmd;
  logic [7:0]  altAddr;
  logic [31:0] altWdata;

  logic [31:0] refMem [256];
  logic        lastPl;
  logic [31:0] expPsRdata;
  logic [31:0] expPlRdata;

  mem_port_arbiter_if bus0 ();
  mem_port_arbiter_if busL1 ();
  mem_port_arbiter_if busL5 ();

  mem_port_arbiter #(.RD_LAT(LAT0)) dut0 (.clk(clk), .rst(rst), .bus(bus0),  .busy(busy0));
  mem_port_arbiter #(.RD_LAT(LAT1)) dut1 (.clk(clk), .rst(rst), .bus(busL1), .busy(busy1));
  mem_port_arbiter #(.RD_LAT(LAT5)) dut5 (.clk(clk), .rst(rst), .bus(busL5), .busy(busy5));

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int a);
    return 32'hC0DE_0000 | 32'(a * 7);
  endfunction

  function automatic int dur(input logic [2:0] cmd);
    return (cmd == CMD_WR) ? 2 : 2 + LAT0;
  endfunction

  // The latency instances only see PL traffic, driven from shared variables.
  assign busL1.ps_req = 1'b0;  assign busL1.ps_cmd = 3'd0;
  assign busL1.ps_addr = 8'd0; assign busL1.ps_wdata = 32'd0;
  assign busL5.ps_req = 1'b0;  assign busL5.ps_cmd = 3'd0;
  assign busL5.ps_addr = 8'd0; assign busL5.ps_wdata = 32'd0;
  assign busL1.pl_req = altReq;   assign busL1.pl_cmd = altCmd;
  assign busL1.pl_addr = altAddr; assign busL1.pl_wdata = altWdata;
  assign busL5.pl_req = altReq;   assign busL5.pl_cmd = altCmd;
  assign busL5.pl_addr = altAddr; assign busL5.pl_wdata = altWdata;

  // Memory models: data is valid on mem_rdata only in the cycle RD_LAT after the read command.
  logic [31:0] mem0 [256];
  logic [31:0] memL1 [256];
  logic [31:0] memL5 [256];
  logic [3:0]  age0, ageL1, ageL5;
  logic [7:0]  rdA0, rdAL1, rdAL5;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) begin
        mem0[i]  <= pat(i);
        memL1[i] <= pat(i);
        memL5[i] <= pat(i);
      end
      age0  <= 4'd0;
      ageL1 <= 4'd0;
      ageL5 <= 4'd0;
    end else begin
      if (bus0.mem_cmd == CMD_WR) mem0[bus0.mem_addr] <= bus0.mem_wdata;
      if (bus0.mem_cmd == CMD_RD) begin age0 <= 4'd1; rdA0 <= bus0.mem_addr; end
      else if (age0 != 4'd0 && age0 != 4'd15) age0 <= age0 + 4'd1;
      if (busL1.mem_cmd == CMD_WR) memL1[busL1.mem_addr] <= busL1.mem_wdata;
      if (busL1.mem_cmd == CMD_RD) begin ageL1 <= 4'd1; rdAL1 <= busL1.mem_addr; end
      else if (ageL1 != 4'd0 && ageL1 != 4'd15) ageL1 <= ageL1 + 4'd1;
      if (busL5.mem_cmd == CMD_WR) memL5[busL5.mem_addr] <= busL5.mem_wdata;
      if (busL5.mem_cmd == CMD_RD) begin ageL5 <= 4'd1; rdAL5 <= busL5.mem_addr; end
      else if (ageL5 != 4'd0 && ageL5 != 4'd15) ageL5 <= ageL5 + 4'd1;
    end
  end

  assign bus0.mem_rdata  = (age0  == 4'(LAT0)) ? mem0[rdA0]   : 32'hDEAD_BEEF;
  assign busL1.mem_rdata = (ageL1 == 4'(LAT1)) ? memL1[rdAL1] : 32'hDEAD_BEEF;
  assign busL5.mem_rdata = (ageL5 == 4'(LAT5)) ? memL5[rdAL5] : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic initModel();
    for (int i = 0; i < 256; i++) refMem[i] = pat(i);
    lastPl     = 1'b1;
    expPsRdata = 32'd0;
    expPlRdata = 32'd0;
  endtask

  task automatic applyStimulus(input string tag,
                               input logic psOn, input logic [2:0] psC, input logic [7:0] psA, input logic [31:0] psW,
                               input logic plOn, input logic [2:0] plC, input logic [7:0] plA, input logic [31:0] plW);
    logic        txPl   [2];
    logic [2:0]  txCmd  [2];
    logic [7:0]  txAddr [2];
    logic [31:0] txW    [2];
    logic [31:0] txRd   [2];
    int          txG    [2];
    int          nTx, last, nextG;
    logic        psV, plV, firstPl;
    psV     = psOn && (psC == CMD_WR || psC == CMD_RD);
    plV     = plOn && (plC == CMD_WR || plC == CMD_RD);
    firstPl = plV && (!psV || !lastPl);
    nTx     = 0;
    nextG   = 1;
    if (psV || plV) begin txPl[0] = firstPl;  nTx = 1; end
    if (psV && plV) begin txPl[1] = !firstPl; nTx = 2; end
    for (int k = 0; k < nTx; k++) begin
      txCmd[k]  = txPl[k] ? plC : psC;
      txAddr[k] = txPl[k] ? plA : psA;
      txW[k]    = txPl[k] ? plW : psW;
      txG[k]    = nextG;
      nextG     = nextG + dur(txCmd[k]);
      lastPl    = txPl[k];
      if (txCmd[k] == CMD_WR) refMem[txAddr[k]] = txW[k];
      else                    txRd[k] = refMem[txAddr[k]];
    end
    last = (nTx == 0) ? 4 : nextG - 1;

    @(negedge clk);
    bus0.ps_req = psOn; bus0.ps_cmd = psC; bus0.ps_addr = psA; bus0.ps_wdata = psW;
    bus0.pl_req = plOn; bus0.pl_cmd = plC; bus0.pl_addr = plA; bus0.pl_wdata = plW;
    for (int c = 1; c <= last; c++) begin
      logic eGps, eGpl, eRps, eRpl, eBusy;
      logic [2:0] eCmd;
      @(negedge clk);
      checkOutput(tag, c, nTx, txPl, txCmd, txAddr, txW, txRd, txG);
      if (bus0.ps_gnt) bus0.ps_req = 1'b0;
      if (bus0.pl_gnt) bus0.pl_req = 1'b0;
    end
    bus0.ps_req = 1'b0;
    bus0.pl_req = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input int c, input int nTx,
                             input logic txPl [2], input logic [2:0] txCmd [2], input logic [7:0] txAddr [2],
                             input logic [31:0] txW [2], input logic [31:0] txRd [2], input int txG [2]);
    logic eGps, eGpl, eRps, eRpl, eBusy;
    logic [2:0] eCmd;
    eGps = 0; eGpl = 0; eRps = 0; eRpl = 0; eBusy = 0; eCmd = CMD_IDLE;
    for (int k = 0; k < nTx; k++) begin
      if (c == txG[k]) begin
        if (txPl[k]) eGpl = 1'b1; else eGps = 1'b1;
        eCmd = txCmd[k];
        chk({tag, "_mem_addr"}, bus0.mem_addr, txAddr[k]);
        chk({tag, "_mem_wdata"}, bus0.mem_wdata, txW[k]);
      end
      if (c >= txG[k] && c <= txG[k] + dur(txCmd[k]) - 2) eBusy = 1'b1;
      if (txCmd[k] == CMD_RD && c > txG[k] && c <= txG[k] + 1 + LAT0)
        chk({tag, "_rd_addr_hold"}, bus0.mem_addr, txAddr[k]);
      if (txCmd[k] == CMD_RD && c == txG[k] + 1 + LAT0) begin
        if (txPl[k]) begin eRpl = 1'b1; expPlRdata = txRd[k]; end
        else         begin eRps = 1'b1; expPsRdata = txRd[k]; end
      end
    end
    chk({tag, "_ps_gnt"},    bus0.ps_gnt,    eGps);
    chk({tag, "_pl_gnt"},    bus0.pl_gnt,    eGpl);
    chk({tag, "_mem_cmd"},   bus0.mem_cmd,   eCmd);
    chk({tag, "_busy"},      busy0,          eBusy);
    chk({tag, "_ps_rvalid"}, bus0.ps_rvalid, eRps);
    chk({tag, "_pl_rvalid"}, bus0.pl_rvalid, eRpl);
    chk({tag, "_ps_rdata"},  bus0.ps_rdata,  expPsRdata);
    chk({tag, "_pl_rdata"},  bus0.pl_rdata,  expPlRdata);
  endtask

  initial begin
    logic firstPl, who, odd;
    logic [31:0] altData;
    rst = 1'b1;
    bus0.ps_req = 0; bus0.ps_cmd = 0; bus0.ps_addr = 0; bus0.ps_wdata = 0;
    bus0.pl_req = 0; bus0.pl_cmd = 0; bus0.pl_addr = 0; bus0.pl_wdata = 0;
    altReq = 0; altCmd = 0; altAddr = 0; altWdata = 0;
    initModel();
    repeat (2) @(negedge clk);
    chk("rst_ps_gnt",    bus0.ps_gnt,    0);
    chk("rst_pl_gnt",    bus0.pl_gnt,    0);
    chk("rst_ps_rvalid", bus0.ps_rvalid, 0);
    chk("rst_pl_rvalid", bus0.pl_rvalid, 0);
    chk("rst_busy",      busy0,          0);
    chk("rst_mem_cmd",   bus0.mem_cmd,   CMD_IDLE);
    chk("rst_mem_addr",  bus0.mem_addr,  0);
    chk("rst_mem_wdata", bus0.mem_wdata, 0);
    chk("rst_ps_rdata",  bus0.ps_rdata,  0);
    chk("rst_pl_rdata",  bus0.pl_rdata,  0);
    rst = 1'b0;

    $display("[TB] simultaneous reads after reset");
    applyStimulus("tie_rd", 1, CMD_RD, 8'd255, 32'd0, 1, CMD_RD, 8'd1, 32'd0);

    $display("[TB] PL write then PL read");
    applyStimulus("pl_wr", 0, 3'd0, 8'd0, 32'd0, 1, CMD_WR, 8'd6, 32'h0000_0F12);
    applyStimulus("pl_rd", 0, 3'd0, 8'd0, 32'd0, 1, CMD_RD, 8'd6, 32'd0);

    $display("[TB] both requesters hold write requests");
    @(negedge clk);
    bus0.ps_req = 1; bus0.ps_cmd = CMD_WR; bus0.ps_addr = 8'h20; bus0.ps_wdata = 32'h1111_0020;
    bus0.pl_req = 1; bus0.pl_cmd = CMD_WR; bus0.pl_addr = 8'h21; bus0.pl_wdata = 32'h2222_0021;
    firstPl = !lastPl;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      odd = (c % 2) == 1;
      who = (((c - 1) / 2) % 2 == 0) ? firstPl : !firstPl;
      chk("hold_ps_gnt",  bus0.ps_gnt, odd && !who);
      chk("hold_pl_gnt",  bus0.pl_gnt, odd && who);
      chk("hold_mem_cmd", bus0.mem_cmd, odd ? CMD_WR : CMD_IDLE);
      chk("hold_busy",    busy0, odd);
      if (odd) begin
        lastPl = who;
        if (who) refMem[8'h21] = 32'h2222_0021; else refMem[8'h20] = 32'h1111_0020;
      end
      if (c == 7) begin bus0.ps_req = 0; bus0.pl_req = 0; end
    end

    $display("[TB] invalid commands");
    applyStimulus("inv4", 1, 3'd4, 8'd3, 32'd5, 0, 3'd0, 8'd0, 32'd0);
    applyStimulus("inv0", 1, 3'd0, 8'd3, 32'd5, 0, 3'd0, 8'd0, 32'd0);
    applyStimulus("rd_hold", 1, CMD_RD, 8'h21, 32'd0, 0, 3'd0, 8'd0, 32'd0);

    $display("[TB] reset during read wait");
    @(negedge clk);
    bus0.pl_req = 1; bus0.pl_cmd = CMD_RD; bus0.pl_addr = 8'd6;
    @(negedge clk);
    chk("mid_pl_gnt", bus0.pl_gnt, 1);
    bus0.pl_req = 0;
    @(negedge clk);
    chk("mid_busy_before", busy0, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_busy",      busy0,          0);
    chk("mid_mem_cmd",   bus0.mem_cmd,   CMD_IDLE);
    chk("mid_pl_rdata",  bus0.pl_rdata,  0);
    chk("mid_mem_addr",  bus0.mem_addr,  0);
    chk("mid_mem_wdata", bus0.mem_wdata, 0);
    @(negedge clk);
    rst = 1'b0;
    initModel();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("mid_pl_rvalid", bus0.pl_rvalid, 0);
      chk("mid_ps_rvalid", bus0.ps_rvalid, 0);
    end

    $display("[TB] random transactions");
    for (int r = 0; r < 40; r++) begin
      logic [2:0]  c1, c2;
      logic [7:0]  a1, a2;
      logic        on1, on2;
      c1  = ($urandom_range(0, 9) < 8) ? (($urandom_range(0, 1) == 1) ? CMD_WR : CMD_RD) : 3'($urandom_range(0, 7));
      c2  = ($urandom_range(0, 9) < 8) ? (($urandom_range(0, 1) == 1) ? CMD_WR : CMD_RD) : 3'($urandom_range(0, 7));
      a1  = ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
      a2  = ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
      on1 = $urandom_range(0, 3) != 0;
      on2 = $urandom_range(0, 3) != 0;
      applyStimulus("rnd", on1, c1, a1, $urandom, on2, c2, a2, $urandom);
    end

    $display("[TB] RD_LAT=1 and RD_LAT=5 instances");
    altData = $urandom;
    @(negedge clk);
    altReq = 1; altCmd = CMD_WR; altAddr = 8'h40; altWdata = altData;
    @(negedge clk);
    chk("l1_wr_gnt", busL1.pl_gnt, 1);
    chk("l5_wr_gnt", busL5.pl_gnt, 1);
    altReq = 0;
    @(negedge clk);
    altReq = 1; altCmd = CMD_RD;
    @(negedge clk);
    chk("l1_rd_gnt", busL1.pl_gnt, 1);
    chk("l5_rd_gnt", busL5.pl_gnt, 1);
    altReq = 0;
    for (int c = 2; c <= 8; c++) begin
      @(negedge clk);
      chk("l1_rvalid", busL1.pl_rvalid, c == 3);
      chk("l5_rvalid", busL5.pl_rvalid, c == 7);
      chk("l1_busy",   busy1, c <= 2);
      chk("l5_busy",   busy5, c <= 6);
      chk("l1_rdata",  busL1.pl_rdata, (c >= 3) ? altData : 32'd0);
      chk("l5_rdata",  busL5.pl_rdata, (c >= 7) ? altData : 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single command/address/data port of the 256 x 32-bit PS/PL shared memory between two requesters: the PS-side loader (PS) and the matrix calculator (PL). Each accepted request becomes exactly one memory transaction: a write or a read. Read data is routed back only to the requester that issued the read. Arbitration is round-robin with one transaction outstanding at a time. The block sits between both masters and the memory model, which keeps its existing command encoding: 2 = write, 3 = read, 4 = idle.

## Interface
Parameters:
- RD_LAT, 2, cycles from the cycle `mem_cmd`=3 is presented until `mem_rdata` is valid (legal range 1-15)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ps_req  in  1  PS transaction request
- ps_cmd  in  3  PS command: 2 = write, 3 = read
- ps_addr  in  8  PS memory address
- ps_wdata  in  32  PS write data
- ps_gnt  out  1  one-cycle pulse: PS transaction accepted
- ps_rvalid  out  1  one-cycle pulse: `ps_rdata` updated
- ps_rdata  out  32  last read data returned to PS
- pl_req, pl_cmd, pl_addr, pl_wdata, pl_gnt, pl_rvalid, pl_rdata  same widths and meaning as the PS ports, for the PL requester
- mem_cmd  out  3  memory command: 2 = write, 3 = read, 4 = idle
- mem_addr  out  8  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data
- busy  out  1  high whenever the state is not IDLE

## Operation
- States: IDLE, ISSUE, RD_WAIT.
- **Valid request:** `x_req`=1 with `x_cmd` equal to 2 or 3. A request with any other cmd value is ignored: no grant and no memory activity.
- **IDLE:**
  - With one valid request, grant it.
  - With two valid requests, grant the requester that was not granted most recently.
  - The last-grant pointer resets to PL, so PS wins the first tie.
  - On a grant: latch cmd, addr and wdata into `mem_*`, set `x_gnt`=1, update the pointer, and go to ISSUE.
- **ISSUE:** lasts exactly one cycle.
  - Clear `gnt` and set `mem_cmd`=4.
  - If the command is a write, go to IDLE.
  - If the command is a read, load the wait counter with RD_LAT-1 and go to RD_WAIT.
- **RD_WAIT:**
  - Decrement the counter each cycle.
  - At counter 0: capture `mem_rdata` into the granted requester's `rdata`, pulse its `rvalid`, and go to IDLE.
- `mem_addr` holds from ISSUE until the cycle `rvalid` is asserted.
- `mem_wdata` holds until the next grant.
- **Requester rule:** hold req, cmd, addr and wdata stable until `gnt` is seen, then drop req on the next edge. A req still high after that edge is treated as a new transaction.
- `x_rdata` holds its value until the next read by that same requester. It is never disturbed by the other requester's reads.
- **Reset values:**
  - all `gnt`, `rvalid` and `busy` = 0
  - `mem_cmd` = 4
  - `mem_addr` = 0, `mem_wdata` = 0
  - `ps_rdata` = 0, `pl_rdata` = 0
  - state = IDLE, pointer = PL, counter = 0

## Timing
- All outputs are registered. Cycle 0 is the cycle in which the request is sampled in IDLE.
- **Write:** `gnt` and `mem_cmd`=2 appear in cycle 1; the block is back in IDLE in cycle 2. Peak throughput is one write per 2 cycles.
- **Read:** `gnt` and `mem_cmd`=3 appear in cycle 1. `mem_rdata` is sampled on the edge ending cycle 1+RD_LAT. `rvalid` is high in cycle 2+RD_LAT, and the block is in IDLE in that same cycle. With RD_LAT=2: request in cycle 0, `rvalid` in cycle 4.
- A new request sampled in the IDLE cycle that carries `rvalid` is granted in the following cycle. No idle bubble is inserted beyond that.
- A request that arrives while `busy`=1 waits; it is evaluated in the next IDLE cycle.
- `ps_gnt` and `pl_gnt` are never high in the same cycle. The same holds for the two `rvalid` outputs.
- **Reset mid-transaction:** takes effect asynchronously. All outputs go to their reset values immediately, the transaction is dropped, and no `rvalid` is produced for it.

## Test plan
- **PL write, then PL read:** `pl_req` with cmd=2, addr=6, wdata=0x0000_0F12, followed by a PL read of addr=6. Expect `pl_gnt` in cycle 1 and `mem_cmd`=2, `mem_addr`=6 for exactly one cycle. The read must return `pl_rdata`=0x0000_0F12 with `pl_rvalid` in cycle 4 (RD_LAT=2).
- **Simultaneous valid requests after reset:** PS read of addr 255 and PL read of addr 1 requested together. Expect PS granted first and PL granted in the cycle after `ps_rvalid`. `ps_rdata` must remain unchanged when `pl_rvalid` fires.
- **Both requesters hold req continuously (writes):** grants must alternate PS, PL, PS, PL, with exactly one grant per 2 cycles.
- **Invalid command:** `ps_req`=1 with cmd=4, then cmd=0. Expect no `ps_gnt`, `mem_cmd` stays 4, and `busy` stays 0.
- **Reset mid-read:** assert rst during RD_WAIT. Expect `busy`=0, `mem_cmd`=4 and `pl_rdata`=0 immediately, with no `rvalid` after rst is released.
- **RD_LAT=1 and RD_LAT=5 builds:** `rvalid` must appear in cycle 3 and cycle 7 respectively, with correct data from a memory model configured to the matching latency.
